z86_hazard_scoreboard: RTL and testbench
========================================

// Module: z86_hazard_scoreboard
// PURPOSE
//  Issue scheduler between DECODE and EXECUTE. Tracks in-flight destination masks (reg_mask_t)
//  for the EX slot and the WB slot. Stalls the decoded instruction on RAW hazards against
//  GPRs, segment registers, memory, IO and implicit SP (stack ops).
//  Sole owner of the ID->EX issue handshake. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//  CNT_W  16  width of stall_cnt (saturates at all-ones)
// PORTS
//  clk           in   1   core clock; single clock domain
//  reset_n       in   1   asynchronous, active-low reset
//  id_valid      in   1   DECODE holds a decoded instruction
//  id_rd_mask    in   15  reg_mask_t of resources read (gpr/mem/seg/stackop/io)
//  id_wr_mask    in   15  reg_mask_t of resources written
//  ex_done       in   1   EX instruction completes this cycle (EX may be multi-cycle)
//  flush         in   1   redirect from EX; only legal with ex_done
//  id_issue      out  1   instruction moves ID->EX this cycle
//  id_stall      out  1   id_valid held due to hazard or busy EX
//  busy_mask     out  15  ex_mask | wb_mask (debug/visibility)
//  stall_cnt     out  CNT_W  cycles with id_stall=1
// BEHAVIOUR
//  - Reset (async, reset_n=0): ex_vld=0, wb_vld=0, ex_mask=0, wb_mask=0, stall_cnt=0.
//    Outputs are therefore id_issue=0, id_stall=0 and busy_mask=0.
//    Reset mid-operation drops all in-flight entries immediately.
//  - hazard (combinational from registered slots):
//      gpr:      |(rd.gpr & (ex.gpr|wb.gpr))
//      seg:      |(rd.seg & (ex.seg|wb.seg))
//      mem/io:   rd.mem & (ex.mem|wb.mem); rd.io & (ex.io|wb.io)
//      stackop:  rd.stackop & (ex.stackop|wb.stackop)
//    Comparisons against an invalid slot contribute 0.
//  - ex_free = ~ex_vld | ex_done.
//  - id_issue = id_valid & ex_free & ~hazard & ~flush.
//  - id_stall = id_valid & ~id_issue.
//  - Per clock edge:
//      wb  <= ex_done ? {1, ex_mask} : {0, 0}   (WB is exactly one cycle)
//      ex  <= id_issue ? {1, id_wr_mask} : (ex_done ? {0, 0} : ex)
//  - Simultaneous events:
//      ex_done & id_issue: EX->WB and ID->EX in the same cycle; the new EX mask is visible next cycle.
//      flush (with ex_done): the EX instruction still retires to WB; issue is blocked that cycle.
//      flush without ex_done is illegal (assertion).
//  - Latency: a RAW-dependent instruction issues 2 cycles after its producer's ex_done cycle
//    (blocked by EX, then by WB). An independent instruction issues in the ex_done cycle.
//  - A slot never blocks on its own producer once retired; wb_mask always clears after one cycle.
//  - stall_cnt increments when id_stall=1. It holds at 2^CNT_W-1 and never wraps.
//  - id_valid=0 yields id_issue=0 and id_stall=0 regardless of hazard.
// CONFIGURATION
//  Z86_REGFILE_FORWARD_EN defined: register file forwards WB write data to same-cycle reads.
//    The gpr and seg terms compare against ex_mask only (WB term dropped).
//    RAW distance becomes 1 cycle.
//    mem/io/stackop terms still check both slots.
//  Undefined: full EX|WB comparison as above; RAW distance is 2 cycles.
// STRUCTURE
//  - z86_package additions:
//      localparam REG_MASK_W = $bits(reg_mask_t).
//      typedef struct packed {logic vld; reg_mask_t m;} sb_slot_t.
//  - reg_mask_t is reused unchanged for id_rd_mask, id_wr_mask and busy_mask.
//  - One sub-module: z86_hazard_cmp. It is pure combinational: (rd_mask, slot) -> hazard bit.
//    It is instantiated once per slot; the forwarding macro gates the WB gpr/seg terms.
//  - Slot registers, the issue logic and stall_cnt live in the top module.
// TESTING
//  1. Reset: hold reset_n=0 with id_valid=1 -> id_issue=0, stall_cnt=0.
//     Release, then id_rd_mask=0 -> id_issue=1 on the first cycle.
//  2. GPR RAW:
//     - Producer writes gpr=8'h01 (AX) and completes with ex_done at cycle t.
//     - Consumer reads AX -> id_stall=1 at t and t+1; issue at t+2.
//     - With Z86_REGFILE_FORWARD_EN defined -> issue at t+1.
//  3. Multi-cycle EX:
//     - ex_done held 0 for 5 cycles; independent id_valid instruction -> id_stall=1 for 5 cycles.
//     - It issues in the cycle ex_done=1; stall_cnt=5.
//  4. Mem/stack:
//     - EX holds wr.mem=1 and the next instruction reads mem -> blocked until WB clears.
//     - Two back-to-back PUSHes (stackop=1) -> second issues 2 cycles after the first's ex_done,
//       with and without the forwarding macro.
//  5. Flush: ex_done=1, flush=1, id_valid=1 and no hazard -> id_issue=0; wb_vld=1 next cycle; ex_vld=0.
//  6. Saturation: with CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/z86_hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// z86_hazard_scoreboard_pkg
// Shared types for the ID->EX issue scoreboard.
//   reg_mask_t : resource mask, one bit per tracked resource
//                gpr[7:0] (AX=bit0 ... DI=bit7), mem, seg[3:0] (ES,CS,SS,DS),
//                stackop (implicit SP use by PUSH/POP/CALL/RET), io
//   sb_slot_t  : one in-flight pipeline slot (valid + destination mask)
// ----------------------------------------------------------------------------
package z86_hazard_scoreboard_pkg;

   typedef struct packed {
      logic [7:0] gpr;
      logic       mem;
      logic [3:0] seg;
      logic       stackop;
      logic       io;
   } reg_mask_t;

   localparam int REG_MASK_W = $bits(reg_mask_t);

   typedef struct packed {
      logic      vld;
      reg_mask_t m;
   } sb_slot_t;

   // A slot only contributes its mask while it holds a live instruction.
   function automatic reg_mask_t slot_mask(input sb_slot_t s);
      return s.vld ? s.m : reg_mask_t'('0);
   endfunction

endpackage

// File: rtl/z86_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// z86_hazard_scoreboard_if
// ID->EX issue handshake between DECODE/EXECUTE and the scoreboard.
//   id_valid    DECODE holds a decoded instruction
//   id_rd_mask  resources read by the decoded instruction
//   id_wr_mask  resources written by the decoded instruction
//   ex_done     EX instruction completes this cycle
//   flush       redirect from EX (only together with ex_done)
//   id_issue    instruction moves ID->EX this cycle
//   id_stall    id_valid held back by a hazard or a busy EX slot
// master : pipeline side (drives requests/completions)
// slave  : scoreboard side (drives issue/stall)
// ----------------------------------------------------------------------------
interface z86_hazard_scoreboard_if;
   import z86_hazard_scoreboard_pkg::*;

   logic      id_valid;
   reg_mask_t id_rd_mask;
   reg_mask_t id_wr_mask;
   logic      ex_done;
   logic      flush;
   logic      id_issue;
   logic      id_stall;

   modport master (
      output id_valid,
      output id_rd_mask,
      output id_wr_mask,
      output ex_done,
      output flush,
      input  id_issue,
      input  id_stall
   );

   modport slave (
      input  id_valid,
      input  id_rd_mask,
      input  id_wr_mask,
      input  ex_done,
      input  flush,
      output id_issue,
      output id_stall
   );

endinterface

// File: rtl/z86_hazard_cmp.sv
// ----------------------------------------------------------------------------
// z86_hazard_cmp
// Pure combinational RAW check of one read mask against one in-flight slot.
//   rd_mask  in   resources read by the instruction in DECODE
//   slot     in   registered in-flight slot (valid + destination mask)
//   hazard   out  1 when the read overlaps a live destination of the slot
// Parameter CHK_REGS: when 0 the gpr and seg terms are ignored (used for the
// WB slot when the register file forwards WB data to same-cycle reads).
// mem, io and stackop are always checked.
// ----------------------------------------------------------------------------
module z86_hazard_cmp
   import z86_hazard_scoreboard_pkg::*;
#(
   parameter bit CHK_REGS = 1'b1
) (
   input  reg_mask_t rd_mask,
   input  sb_slot_t  slot,
   output logic      hazard
);

   logic gpr_hit;
   logic seg_hit;
   logic mem_hit;
   logic io_hit;
   logic stk_hit;

   always_comb begin
      gpr_hit = CHK_REGS & (|(rd_mask.gpr & slot.m.gpr));
      seg_hit = CHK_REGS & (|(rd_mask.seg & slot.m.seg));
      mem_hit = rd_mask.mem & slot.m.mem;
      io_hit  = rd_mask.io & slot.m.io;
      stk_hit = rd_mask.stackop & slot.m.stackop;
      // An empty slot never blocks, whatever stale mask it might carry.
      hazard  = slot.vld & (gpr_hit | seg_hit | mem_hit | io_hit | stk_hit);
   end

endmodule

// File: rtl/z86_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// z86_hazard_scoreboard
// Issue scheduler between DECODE and EXECUTE. Tracks the destination masks of
// the instruction in EX and the one in WB, stalls the decoded instruction on
// RAW hazards (gpr, seg, mem, io, implicit SP) and owns the ID->EX handshake.
// Also counts stalled cycles in a saturating counter.
//
// Parameters
//   CNT_W      width of stall_cnt (saturates at all-ones)
// Ports
//   clk        core clock
//   reset_n    asynchronous active-low reset; drops all in-flight entries
//   sb         z86_hazard_scoreboard_if.slave issue handshake
//   busy_mask  union of live EX and WB destination masks (visibility)
//   stall_cnt  number of cycles with id_stall=1
//
// Configuration macro Z86_REGFILE_FORWARD_EN:
//   defined   -> register file forwards WB data, so gpr/seg reads only check
//                the EX slot (RAW distance 1 cycle)
//   undefined -> gpr/seg reads check EX and WB (RAW distance 2 cycles)
// ----------------------------------------------------------------------------
module z86_hazard_scoreboard
   import z86_hazard_scoreboard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   z86_hazard_scoreboard_if.slave sb,
   output reg_mask_t              busy_mask,
   output logic [CNT_W-1:0]       stall_cnt
);

`ifdef Z86_REGFILE_FORWARD_EN
   localparam bit WB_CHK_REGS = 1'b0;
`else
   localparam bit WB_CHK_REGS = 1'b1;
`endif

   sb_slot_t ex_slot_p0;
   sb_slot_t wb_slot_p1;

   logic hazard_ex;
   logic hazard_wb;
   logic hazard;
   logic ex_free;
   logic issue;
   logic stall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // ---- ID stage: hazard check against registered slots ----
   z86_hazard_cmp #(
      .CHK_REGS (1'b1)
   ) u_cmp_ex (
      .rd_mask (sb.id_rd_mask),
      .slot    (ex_slot_p0),
      .hazard  (hazard_ex)
   );

   z86_hazard_cmp #(
      .CHK_REGS (WB_CHK_REGS)
   ) u_cmp_wb (
      .rd_mask (sb.id_rd_mask),
      .slot    (wb_slot_p1),
      .hazard  (hazard_wb)
   );

   always_comb begin
      hazard  = hazard_ex | hazard_wb;
      // EX accepts a new instruction in the same cycle its current one retires.
      ex_free = ~ex_slot_p0.vld | sb.ex_done;
      // reset_n gating keeps the handshake quiet while the slots are held in reset.
      issue   = reset_n & sb.id_valid & ex_free & ~hazard & ~sb.flush;
      stall   = reset_n & sb.id_valid & ~issue;
   end

   assign sb.id_issue = issue;
   assign sb.id_stall = stall;
   assign busy_mask   = reg_mask_t'(slot_mask(ex_slot_p0) | slot_mask(wb_slot_p1));

   // ---- EX slot (p0) and WB slot (p1) registers ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_slot_p0 <= '0;
         wb_slot_p1 <= '0;
         stall_cnt  <= '0;
      end else begin
         // WB lives exactly one cycle; a flushed EX instruction still retires.
         wb_slot_p1 <= sb.ex_done ? sb_slot_t'({1'b1, ex_slot_p0.m}) : sb_slot_t'('0);
         if (issue) begin
            ex_slot_p0 <= sb_slot_t'({1'b1, sb.id_wr_mask});
         end else if (sb.ex_done) begin
            ex_slot_p0 <= '0;
         end
         if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
      end
   end

   // A redirect is only meaningful when the EX instruction completes.
   flush_needs_done : assert property (@(posedge clk) disable iff (!reset_n)
                                       sb.flush |-> sb.ex_done);

endmodule

// File: tb/tb_z86_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_z86_hazard_scoreboard
// Directed stimulus for z86_hazard_scoreboard (CNT_W=4). Each driven cycle
// pushes its hand-computed expected outputs into a queue; a monitor on the
// falling edge pops one entry per cycle and compares it with the DUT.
// Honours Z86_REGFILE_FORWARD_EN for the gpr RAW distance.
// ----------------------------------------------------------------------------
module tb_z86_hazard_scoreboard;
   import z86_hazard_scoreboard_pkg::*;

   localparam int CNT_W = 4;

   localparam logic [14:0] NONE = 15'h0000;
   localparam logic [14:0] AX   = 15'h0080;  // gpr bit0
   localparam logic [14:0] BX   = 15'h0100;  // gpr bit1
   localparam logic [14:0] MEM  = 15'h0040;
   localparam logic [14:0] STK  = 15'h0002;

   typedef struct {
      string       nm;
      logic        iss;
      logic        stl;
      logic [14:0] busy;
      logic [3:0]  cnt;
   } exp_t;

   logic             clk;
   logic             reset_n;
   reg_mask_t        busy_mask;
   logic [CNT_W-1:0] stall_cnt;

   int   checks;
   int   errors;
   exp_t q[$];
   exp_t mon_e;

   z86_hazard_scoreboard_if sb_if ();

   z86_hazard_scoreboard #(
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sb        (sb_if),
      .busy_mask (busy_mask),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %0h required %0h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expected entry per driven cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk(mon_e.nm, "id_issue",  {15'd0, sb_if.id_issue}, {15'd0, mon_e.iss});
         chk(mon_e.nm, "id_stall",  {15'd0, sb_if.id_stall}, {15'd0, mon_e.stl});
         chk(mon_e.nm, "busy_mask", {1'b0, busy_mask},       {1'b0, mon_e.busy});
         chk(mon_e.nm, "stall_cnt", {12'd0, stall_cnt},      {12'd0, mon_e.cnt});
      end
   end

   // Drive one cycle (called just after a rising edge) and queue its expectation.
   task automatic cyc(input logic v, input logic [14:0] rd, input logic [14:0] wr,
                      input logic done, input logic fl,
                      input logic e_iss, input logic e_stl,
                      input logic [14:0] e_busy, input logic [3:0] e_cnt, input string nm);
      exp_t e;
      sb_if.id_valid   = v;
      sb_if.id_rd_mask = rd;
      sb_if.id_wr_mask = wr;
      sb_if.ex_done    = done;
      sb_if.flush      = fl;
      e.nm   = nm;
      e.iss  = e_iss;
      e.stl  = e_stl;
      e.busy = e_busy;
      e.cnt  = e_cnt;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v);
      reset_n = 1'b0;
      cyc(v, NONE, NONE, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 4'd0, "rst_hold0");
      cyc(v, NONE, NONE, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 4'd0, "rst_hold1");
      reset_n = 1'b1;
   endtask

   initial begin
      int w;
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      sb_if.id_valid   = 1'b0;
      sb_if.id_rd_mask = '0;
      sb_if.id_wr_mask = '0;
      sb_if.ex_done    = 1'b0;
      sb_if.flush      = 1'b0;
      @(posedge clk);
      #1;

      // 1. Reset with id_valid high, then first issue
      do_reset(1'b1);
      cyc(1, NONE, NONE, 0, 0, 1, 0, NONE, 4'd0, "first_issue");

      // 2. GPR RAW on AX, producer retires at t
      do_reset(1'b0);
      cyc(1, NONE, AX,   0, 0, 1, 0, NONE, 4'd0, "raw_prod");
      cyc(1, AX,   NONE, 1, 0, 0, 1, AX,   4'd0, "raw_t");
`ifdef Z86_REGFILE_FORWARD_EN
      cyc(1, AX,   NONE, 0, 0, 1, 0, AX,   4'd1, "raw_t1_fwd");
      cyc(0, NONE, NONE, 0, 0, 0, 0, NONE, 4'd1, "raw_t2_fwd");
`else
      cyc(1, AX,   NONE, 0, 0, 0, 1, AX,   4'd1, "raw_t1");
      cyc(1, AX,   NONE, 0, 0, 1, 0, NONE, 4'd2, "raw_t2");
`endif

      // 3. Multi-cycle EX, independent consumer
      do_reset(1'b0);
      cyc(1, NONE, BX,   0, 0, 1, 0, NONE, 4'd0, "mc_prod");
      for (int i = 0; i < 5; i++)
         cyc(1, NONE, NONE, 0, 0, 0, 1, BX, 4'(i), "mc_busy");
      cyc(1, NONE, NONE, 1, 0, 1, 0, BX,   4'd5, "mc_done_issue");
      cyc(0, NONE, NONE, 0, 0, 0, 0, BX,   4'd5, "mc_wb");
      cyc(0, NONE, NONE, 1, 0, 0, 0, NONE, 4'd5, "mc_retire");

      // 4a. Memory RAW: blocked by EX, then WB
      do_reset(1'b0);
      cyc(1, NONE, MEM,  0, 0, 1, 0, NONE, 4'd0, "mem_prod");
      cyc(1, MEM,  NONE, 0, 0, 0, 1, MEM,  4'd0, "mem_ex");
      cyc(1, MEM,  NONE, 1, 0, 0, 1, MEM,  4'd1, "mem_done");
      cyc(1, MEM,  NONE, 0, 0, 0, 1, MEM,  4'd2, "mem_wb");
      cyc(1, MEM,  NONE, 0, 0, 1, 0, NONE, 4'd3, "mem_issue");

      // 4b. Back-to-back PUSH: 2-cycle distance in both builds
      do_reset(1'b0);
      cyc(1, STK,  STK,  0, 0, 1, 0, NONE, 4'd0, "push1");
      cyc(1, STK,  STK,  1, 0, 0, 1, STK,  4'd0, "push2_t");
      cyc(1, STK,  STK,  0, 0, 0, 1, STK,  4'd1, "push2_t1");
      cyc(1, STK,  STK,  0, 0, 1, 0, NONE, 4'd2, "push2_t2");
      cyc(0, NONE, NONE, 1, 0, 0, 0, STK,  4'd2, "push2_done");
      cyc(0, NONE, NONE, 0, 0, 0, 0, STK,  4'd2, "push2_wb");
      cyc(0, NONE, NONE, 0, 0, 0, 0, NONE, 4'd2, "push2_idle");

      // 5. Flush: EX retires to WB, issue blocked, EX left empty
      do_reset(1'b0);
      cyc(1, NONE, AX,   0, 0, 1, 0, NONE, 4'd0, "fl_prod");
      cyc(1, BX,   NONE, 1, 1, 0, 1, AX,   4'd0, "fl_blocked");
      cyc(1, BX,   NONE, 0, 0, 1, 0, AX,   4'd1, "fl_wb_ex_empty");
      cyc(0, NONE, NONE, 1, 0, 0, 0, NONE, 4'd1, "fl_retire");

      // 6. Saturation of the 4-bit counter, then reset mid-operation
      do_reset(1'b0);
      cyc(1, NONE, AX,   0, 0, 1, 0, NONE, 4'd0, "sat_prod");
      for (int i = 0; i < 20; i++)
         cyc(1, AX, NONE, 0, 0, 0, 1, AX, (i < 15) ? 4'(i) : 4'hF, "sat_stall");
      cyc(0, NONE, NONE, 0, 0, 0, 0, AX,   4'hF, "sat_hold");
      reset_n = 1'b0;
      cyc(1, AX,   NONE, 0, 0, 0, 0, NONE, 4'd0, "midop_reset");
      reset_n = 1'b1;
      cyc(1, AX,   NONE, 0, 0, 1, 0, NONE, 4'd0, "post_reset_issue");
      cyc(0, NONE, NONE, 0, 0, 0, 0, NONE, 4'd0, "post_reset_idle");

      w = 0;
      while (q.size() != 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries required 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
